mpe_out2in_accum: RTL and testbench

- Reverse-direction companion to the MPE input-to-output window mapper.
- Takes one OUT_H x OUT_W output-gradient tile per kernel position (kh, kw) and scatter-accumulates it into an IN_H x IN_W input-shaped buffer at acc[i*stride+kh][j*stride+kw].
- Used for transposed convolution and backprop through the MPE.
- Sequences kernel positions itself and hands the finished buffer downstream over a valid/ready handshake.

---
 rtl/mpe_pkg.sv | 25 ++
 rtl/mpe_acc_cell.sv | 53 +++++
 rtl/mpe_out2in_accum.sv | 176 +++++++++++++++++
 tb/tb_mpe_out2in_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpe_pkg.sv
// Shared types and default geometry for the MPE output-to-input accumulator.
// Defaults track the OUTPUT_*/INPUT_*/KERNEL_* dimensions used system-wide.
package mpe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } mpe_state_e;

    localparam int MPE_BIN_LEN = 16;
    localparam int MPE_ACC_LEN = 24;
    localparam int MPE_OUT_H   = 4;
    localparam int MPE_OUT_W   = 4;
    localparam int MPE_K_H     = 3;
    localparam int MPE_K_W     = 3;
    localparam int MPE_IN_H    = 12;
    localparam int MPE_IN_W    = 12;

    // Smallest buffer dimension that holds every contribution at stride s.
    function automatic int mpe_min_in_dim(input int out_dim, input int k_dim, input int s);
        return (out_dim - 1) * s + k_dim;
    endfunction

endpackage

// File: rtl/mpe_acc_cell.sv
// One accumulator element: sign-extending add with clear; saturating when
// MPE_OUT2IN_SATURATE_EN is defined, wrapping otherwise.
module mpe_acc_cell #(
    parameter int BIN_LEN = 16,
    parameter int ACC_LEN = 24
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      clear_i,
    input  logic                      en_i,
    input  logic signed [BIN_LEN-1:0] din_i,
    output logic        [ACC_LEN-1:0] acc_o
`ifdef MPE_OUT2IN_SATURATE_EN
    ,
    output logic                      sat_o
`endif
);

    logic signed [ACC_LEN-1:0] acc_q, acc_d, ext, res;

    assign ext = ACC_LEN'(din_i);

`ifdef MPE_OUT2IN_SATURATE_EN
    logic signed [ACC_LEN:0] sum;
    logic                    ovf;

    // One guard bit exposes overflow; its sign picks the clamp direction.
    assign sum = (ACC_LEN+1)'(ext) + (ACC_LEN+1)'(acc_q);
    assign ovf = sum[ACC_LEN] ^ sum[ACC_LEN-1];
    assign sat_o = en_i && !clear_i && ovf;

    always_comb begin
        res = sum[ACC_LEN-1:0];
        if (ovf) res = sum[ACC_LEN] ? {1'b1, {(ACC_LEN-1){1'b0}}} : {1'b0, {(ACC_LEN-1){1'b1}}};
    end
`else
    assign res = ext + acc_q;
`endif

    always_comb begin
        acc_d = acc_q;
        if (clear_i)   acc_d = '0;
        else if (en_i) acc_d = res;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mpe_out2in_accum.sv
// Scatter-accumulates per-kernel-position output tiles into an input-shaped buffer.
// Optional MPE_OUT2IN_SATURATE_EN: saturating accumulate plus sticky sat_flag_o.
module mpe_out2in_accum
    import mpe_pkg::*;
#(
    parameter int BIN_LEN = MPE_BIN_LEN,
    parameter int ACC_LEN = MPE_ACC_LEN,
    parameter int OUT_H   = MPE_OUT_H,
    parameter int OUT_W   = MPE_OUT_W,
    parameter int K_H     = MPE_K_H,
    parameter int K_W     = MPE_K_W,
    parameter int IN_H    = MPE_IN_H,
    parameter int IN_W    = MPE_IN_W
) (
    input  logic                                        clock_i,
    input  logic                                        reset_i,
    input  logic                                        start_i,
    input  logic [2:0]                                  stride_i,
    output logic                                        busy_o,
    output logic                                        cfg_err_o,
    input  logic                                        tile_valid_i,
    output logic                                        tile_ready_o,
    input  logic [OUT_H-1:0][OUT_W-1:0][BIN_LEN-1:0]    tile_vals_i,
    output logic [$clog2(K_H > 1 ? K_H : 2)-1:0]        kh_idx_o,
    output logic [$clog2(K_W > 1 ? K_W : 2)-1:0]        kw_idx_o,
    output logic                                        acc_valid_o,
    input  logic                                        acc_ready_i,
    output logic [IN_H-1:0][IN_W-1:0][ACC_LEN-1:0]      acc_vals_o,
    output logic                                        drop_flag_o
`ifdef MPE_OUT2IN_SATURATE_EN
    ,
    output logic                                        sat_flag_o
`endif
);

    localparam int KHW = $clog2(K_H > 1 ? K_H : 2);
    localparam int KWW = $clog2(K_W > 1 ? K_W : 2);
    localparam int RSW = $clog2(OUT_H > 1 ? OUT_H : 2);
    localparam int CSW = $clog2(OUT_W > 1 ? OUT_W : 2);
    localparam logic [KHW-1:0] KH_LAST = KHW'(K_H - 1);
    localparam logic [KWW-1:0] KW_LAST = KWW'(K_W - 1);

    mpe_state_e     state_q, state_d;
    logic [2:0]     stride_q;
    logic [KHW-1:0] kh_q;
    logic [KWW-1:0] kw_q;
    logic           drop_q, cfg_err_q;
    logic           xfer, start_ok, acc_clr;

    logic [15:0]    row_tgt [OUT_H];
    logic [15:0]    col_tgt [OUT_W];
    logic [IN_H-1:0] row_hit;
    logic [IN_W-1:0] col_hit;
    logic [RSW-1:0] row_sel [IN_H];
    logic [CSW-1:0] col_sel [IN_W];
    logic           drop_row, drop_col;

    assign start_ok = (state_q == ST_IDLE) && start_i && (stride_i != 3'd0);
    assign xfer     = tile_ready_o && tile_valid_i;
    assign acc_clr  = acc_valid_o && acc_ready_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_ACCUM;
            ST_ACCUM: if (xfer && kh_q == KH_LAST && kw_q == KW_LAST) state_d = ST_DONE;
            ST_DONE:  if (acc_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        tile_ready_o = (state_q == ST_ACCUM);
        acc_valid_o  = (state_q == ST_DONE);
    end

    // Each tile row/col lands on exactly one buffer row/col; a buffer cell therefore
    // sees at most one tile element per transfer, selected by row_sel/col_sel.
    always_comb begin
        row_hit  = '0;
        drop_row = 1'b0;
        for (int i = 0; i < OUT_H; i++) row_tgt[i] = 16'(i) * 16'(stride_q) + 16'(kh_q);
        for (int r = 0; r < IN_H; r++) begin
            row_sel[r] = '0;
            for (int i = 0; i < OUT_H; i++)
                if (row_tgt[i] == 16'(r)) begin
                    row_hit[r] = 1'b1;
                    row_sel[r] = RSW'(i);
                end
        end
        for (int i = 0; i < OUT_H; i++) if (row_tgt[i] >= 16'(IN_H)) drop_row = 1'b1;
    end

    always_comb begin
        col_hit  = '0;
        drop_col = 1'b0;
        for (int j = 0; j < OUT_W; j++) col_tgt[j] = 16'(j) * 16'(stride_q) + 16'(kw_q);
        for (int c = 0; c < IN_W; c++) begin
            col_sel[c] = '0;
            for (int j = 0; j < OUT_W; j++)
                if (col_tgt[j] == 16'(c)) begin
                    col_hit[c] = 1'b1;
                    col_sel[c] = CSW'(j);
                end
        end
        for (int j = 0; j < OUT_W; j++) if (col_tgt[j] >= 16'(IN_W)) drop_col = 1'b1;
    end

`ifdef MPE_OUT2IN_SATURATE_EN
    logic [IN_H-1:0][IN_W-1:0] sat_hit;
    logic                      sat_q;
    assign sat_flag_o = sat_q;

    always_ff @(posedge clock_i) begin
        if (reset_i)       sat_q <= 1'b0;
        else if (start_ok) sat_q <= 1'b0;
        else if (|sat_hit) sat_q <= 1'b1;
    end
`endif

    for (genvar r = 0; r < IN_H; r++) begin : g_row
        for (genvar c = 0; c < IN_W; c++) begin : g_col
            logic en;
            assign en = xfer && row_hit[r] && col_hit[c];
            mpe_acc_cell #(.BIN_LEN(BIN_LEN), .ACC_LEN(ACC_LEN)) u_cell (
                .clock_i (clock_i),
                .reset_i (reset_i),
                .clear_i (acc_clr),
                .en_i    (en),
                .din_i   (tile_vals_i[row_sel[r]][col_sel[c]]),
                .acc_o   (acc_vals_o[r][c])
`ifdef MPE_OUT2IN_SATURATE_EN
                ,
                .sat_o   (sat_hit[r][c])
`endif
            );
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stride_q  <= 3'd1;
            kh_q      <= '0;
            kw_q      <= '0;
            drop_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == ST_IDLE) && start_i && (stride_i == 3'd0);
            if (start_ok) begin
                stride_q <= stride_i;
                drop_q   <= 1'b0;
            end
            if (xfer) begin
                if (drop_row || drop_col) drop_q <= 1'b1;
                if (kw_q == KW_LAST) begin
                    kw_q <= '0;
                    kh_q <= (kh_q == KH_LAST) ? '0 : kh_q + 1'b1;
                end else begin
                    kw_q <= kw_q + 1'b1;
                end
            end
        end
    end

    assign kh_idx_o    = kh_q;
    assign kw_idx_o    = kw_q;
    assign drop_flag_o = drop_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_mpe_out2in_accum.sv
// Directed bench: default 12x12/ACC24, a 6x6 buffer variant and an ACC_LEN=16 variant share stimulus.
module tb_mpe_out2in_accum;

    logic clock = 1'b0;
    logic reset, start, tile_valid, acc_ready;
    logic [2:0] stride;
    logic [3:0][3:0][15:0] tile;

    logic busy_m, cerr_m, trdy_m, aval_m, drop_m;
    logic [1:0] kh_m, kw_m;
    logic [11:0][11:0][23:0] acc_m;
    logic busy_6, cerr_6, trdy_6, aval_6, drop_6;
    logic [1:0] kh_6, kw_6;
    logic [5:0][5:0][23:0] acc_6;
    logic busy_16, cerr_16, trdy_16, aval_16, drop_16;
    logic [1:0] kh_16, kw_16;
    logic [11:0][11:0][15:0] acc_16;
`ifdef MPE_OUT2IN_SATURATE_EN
    logic sat_m, sat_6, sat_16;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mpe_out2in_accum u_dut (
        .clock_i(clock), .reset_i(reset), .start_i(start), .stride_i(stride),
        .busy_o(busy_m), .cfg_err_o(cerr_m), .tile_valid_i(tile_valid), .tile_ready_o(trdy_m),
        .tile_vals_i(tile), .kh_idx_o(kh_m), .kw_idx_o(kw_m), .acc_valid_o(aval_m),
        .acc_ready_i(acc_ready), .acc_vals_o(acc_m), .drop_flag_o(drop_m)
`ifdef MPE_OUT2IN_SATURATE_EN
        , .sat_flag_o(sat_m)
`endif
    );

    mpe_out2in_accum #(.IN_H(6), .IN_W(6)) u_dut6 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .stride_i(stride),
        .busy_o(busy_6), .cfg_err_o(cerr_6), .tile_valid_i(tile_valid), .tile_ready_o(trdy_6),
        .tile_vals_i(tile), .kh_idx_o(kh_6), .kw_idx_o(kw_6), .acc_valid_o(aval_6),
        .acc_ready_i(acc_ready), .acc_vals_o(acc_6), .drop_flag_o(drop_6)
`ifdef MPE_OUT2IN_SATURATE_EN
        , .sat_flag_o(sat_6)
`endif
    );

    mpe_out2in_accum #(.ACC_LEN(16)) u_dut16 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .stride_i(stride),
        .busy_o(busy_16), .cfg_err_o(cerr_16), .tile_valid_i(tile_valid), .tile_ready_o(trdy_16),
        .tile_vals_i(tile), .kh_idx_o(kh_16), .kw_idx_o(kw_16), .acc_valid_o(aval_16),
        .acc_ready_i(acc_ready), .acc_vals_o(acc_16), .drop_flag_o(drop_16)
`ifdef MPE_OUT2IN_SATURATE_EN
        , .sat_flag_o(sat_16)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) tile[i][j] = v;
    endtask

    task automatic start_job(input logic [2:0] s);
        start = 1'b1; stride = s;
        step();
        start = 1'b0;
    endtask

    // n back-to-back tiles; tile number 'special' carries vs, all others v.
    task automatic feed(input int n, input logic [15:0] v, input int special, input logic [15:0] vs);
        for (int k = 0; k < n; k++) begin
            tile_valid = 1'b1;
            fill(k == special ? vs : v);
            step();
        end
        tile_valid = 1'b0;
    endtask

    task automatic ack();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stride = 3'd2;
        step(); step();
        reset = 1'b0; start = 1'b0;
        checks++; if (busy_m !== 1'b0 || trdy_m !== 1'b0 || aval_m !== 1'b0) begin failures++; $display("FAIL reset_ctrl busy=%b trdy=%b aval=%b exp 0", busy_m, trdy_m, aval_m); end
        checks++; if (cerr_m !== 1'b0 || drop_m !== 1'b0) begin failures++; $display("FAIL reset_flags cerr=%b drop=%b exp 0", cerr_m, drop_m); end
        checks++; if (kh_m !== 2'd0 || kw_m !== 2'd0) begin failures++; $display("FAIL reset_idx kh=%0d kw=%0d exp 0", kh_m, kw_m); end
        checks++; if (acc_m !== '0) begin failures++; $display("FAIL reset_acc nonzero buffer"); end
        step();
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_wins busy=%b exp 0", busy_m); end
    endtask

    task automatic test_basic();
        acc_ready = 1'b1;
        start_job(3'd1);
        checks++; if (busy_m !== 1'b1 || trdy_m !== 1'b1) begin failures++; $display("FAIL basic_start busy=%b trdy=%b exp 1", busy_m, trdy_m); end
        feed(8, 16'd1, -1, 16'd0);
        checks++; if (aval_m !== 1'b0 || kh_m !== 2'd2 || kw_m !== 2'd2) begin failures++; $display("FAIL basic_8 aval=%b kh=%0d kw=%0d exp 0/2/2", aval_m, kh_m, kw_m); end
        feed(1, 16'd1, -1, 16'd0);
        checks++; if (aval_m !== 1'b1 || kh_m !== 2'd0 || kw_m !== 2'd0) begin failures++; $display("FAIL basic_done aval=%b kh=%0d kw=%0d exp 1/0/0", aval_m, kh_m, kw_m); end
        checks++; if (acc_m[2][2] !== 24'd9) begin failures++; $display("FAIL basic_a22 act=%0d exp 9", acc_m[2][2]); end
        checks++; if (acc_m[3][3] !== 24'd9) begin failures++; $display("FAIL basic_a33 act=%0d exp 9", acc_m[3][3]); end
        checks++; if (acc_m[0][0] !== 24'd1) begin failures++; $display("FAIL basic_a00 act=%0d exp 1", acc_m[0][0]); end
        checks++; if (acc_m[0][1] !== 24'd2) begin failures++; $display("FAIL basic_a01 act=%0d exp 2", acc_m[0][1]); end
        checks++; if (acc_m[5][5] !== 24'd1) begin failures++; $display("FAIL basic_a55 act=%0d exp 1", acc_m[5][5]); end
        checks++; if (acc_m[11][11] !== 24'd0 || acc_m[6][6] !== 24'd0) begin failures++; $display("FAIL basic_far a1111=%0d a66=%0d exp 0", acc_m[11][11], acc_m[6][6]); end
        checks++; if (drop_m !== 1'b0) begin failures++; $display("FAIL basic_drop act=%b exp 0", drop_m); end
        step();
        acc_ready = 1'b0;
        checks++; if (aval_m !== 1'b0 || busy_m !== 1'b0 || acc_m[2][2] !== 24'd0) begin failures++; $display("FAIL basic_clear aval=%b busy=%b a22=%0d exp 0", aval_m, busy_m, acc_m[2][2]); end
    endtask

    task automatic test_stride2();
        start_job(3'd2);
        feed(9, 16'd0, 8, 16'd7);
        checks++; if (acc_m[2][2] !== 24'd7 || acc_m[8][8] !== 24'd7) begin failures++; $display("FAIL s2_hit a22=%0d a88=%0d exp 7", acc_m[2][2], acc_m[8][8]); end
        checks++; if (acc_m[4][6] !== 24'd7) begin failures++; $display("FAIL s2_a46 act=%0d exp 7", acc_m[4][6]); end
        checks++; if (acc_m[3][3] !== 24'd0 || acc_m[2][3] !== 24'd0) begin failures++; $display("FAIL s2_gap a33=%0d a23=%0d exp 0", acc_m[3][3], acc_m[2][3]); end
        checks++; if (drop_m !== 1'b0) begin failures++; $display("FAIL s2_drop act=%b exp 0", drop_m); end
        ack();
    endtask

    task automatic test_drop();
        start_job(3'd2);
        feed(9, 16'd1, -1, 16'd0);
        checks++; if (drop_6 !== 1'b1) begin failures++; $display("FAIL drop6_set act=%b exp 1", drop_6); end
        checks++; if (acc_6[0][0] !== 24'd1 || acc_6[5][5] !== 24'd1) begin failures++; $display("FAIL drop6_edge a00=%0d a55=%0d exp 1", acc_6[0][0], acc_6[5][5]); end
        checks++; if (acc_6[4][4] !== 24'd4) begin failures++; $display("FAIL drop6_a44 act=%0d exp 4", acc_6[4][4]); end
        checks++; if (drop_m !== 1'b0 || acc_m[8][8] !== 24'd1 || acc_m[4][4] !== 24'd4) begin failures++; $display("FAIL drop_main drop=%b a88=%0d a44=%0d exp 0/1/4", drop_m, acc_m[8][8], acc_m[4][4]); end
        ack();
        checks++; if (drop_6 !== 1'b1) begin failures++; $display("FAIL drop6_sticky act=%b exp 1", drop_6); end
        start_job(3'd1);
        checks++; if (drop_6 !== 1'b0 || busy_6 !== 1'b1) begin failures++; $display("FAIL drop6_clear drop=%b busy=%b exp 0/1", drop_6, busy_6); end
        feed(9, 16'd0, -1, 16'd0);
        ack();
    endtask

    task automatic test_backpressure();
        int exp_n = 0;
        int cyc = 0;
        start_job(3'd1);
        while (exp_n < 9 && cyc < 40) begin
            checks++; if (kh_m !== 2'(exp_n / 3) || kw_m !== 2'(exp_n % 3)) begin failures++; $display("FAIL bp_idx n=%0d kh=%0d kw=%0d exp %0d/%0d", exp_n, kh_m, kw_m, exp_n / 3, exp_n % 3); end
            tile_valid = (cyc % 2 == 0);
            fill(16'd1);
            step();
            if (tile_valid) exp_n++;
            cyc++;
        end
        tile_valid = 1'b0;
        checks++; if (exp_n != 9 || aval_m !== 1'b1) begin failures++; $display("FAIL bp_reach_done n=%0d aval=%b exp 9/1", exp_n, aval_m); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (aval_m !== 1'b1 || trdy_m !== 1'b0 || acc_m[2][2] !== 24'd9 || acc_m[0][1] !== 24'd2) begin failures++; $display("FAIL bp_hold k=%0d aval=%b trdy=%b a22=%0d a01=%0d exp 1/0/9/2", k, aval_m, trdy_m, acc_m[2][2], acc_m[0][1]); end
            step();
        end
        ack();
        checks++; if (acc_m !== '0 || aval_m !== 1'b0) begin failures++; $display("FAIL bp_clear aval=%b a22=%0d exp 0", aval_m, acc_m[2][2]); end
    endtask

    task automatic test_control();
        start = 1'b1; stride = 3'd0;
        step();
        start = 1'b0;
        checks++; if (cerr_m !== 1'b1 || busy_m !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse cerr=%b busy=%b exp 1/0", cerr_m, busy_m); end
        step();
        checks++; if (cerr_m !== 1'b0 || busy_m !== 1'b0) begin failures++; $display("FAIL cfg_err_end cerr=%b busy=%b exp 0/0", cerr_m, busy_m); end
        start_job(3'd1);
        feed(2, 16'd1, -1, 16'd0);
        start = 1'b1; stride = 3'd3; tile_valid = 1'b1; fill(16'd1);
        step();
        start = 1'b0; tile_valid = 1'b0;
        checks++; if (busy_m !== 1'b1 || kh_m !== 2'd1 || kw_m !== 2'd0) begin failures++; $display("FAIL start_in_accum busy=%b kh=%0d kw=%0d exp 1/1/0", busy_m, kh_m, kw_m); end
        feed(1, 16'd1, -1, 16'd0);
        checks++; if (acc_m[0][3] !== 24'd3 || acc_m[1][0] !== 24'd2) begin failures++; $display("FAIL partial a03=%0d a10=%0d exp 3/2", acc_m[0][3], acc_m[1][0]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (busy_m !== 1'b0 || kh_m !== 2'd0 || kw_m !== 2'd0 || aval_m !== 1'b0) begin failures++; $display("FAIL midjob_reset busy=%b kh=%0d kw=%0d aval=%b exp 0", busy_m, kh_m, kw_m, aval_m); end
        checks++; if (acc_m !== '0) begin failures++; $display("FAIL midjob_reset_acc a03=%0d exp 0", acc_m[0][3]); end
    endtask

    task automatic test_arith();
        start_job(3'd1);
        feed(9, 16'h7FFF, -1, 16'd0);
        checks++; if (acc_m[3][3] !== 24'h047FF7) begin failures++; $display("FAIL arith_wide act=%h exp 047ff7", acc_m[3][3]); end
`ifdef MPE_OUT2IN_SATURATE_EN
        checks++; if (acc_16[3][3] !== 16'h7FFF) begin failures++; $display("FAIL arith_sat33 act=%h exp 7fff", acc_16[3][3]); end
        checks++; if (acc_16[4][4] !== 16'h7FFF) begin failures++; $display("FAIL arith_sat44 act=%h exp 7fff", acc_16[4][4]); end
        checks++; if (sat_16 !== 1'b1 || sat_m !== 1'b0) begin failures++; $display("FAIL arith_satflag s16=%b sm=%b exp 1/0", sat_16, sat_m); end
`else
        checks++; if (acc_16[3][3] !== 16'h7FF7) begin failures++; $display("FAIL arith_wrap33 act=%h exp 7ff7", acc_16[3][3]); end
        checks++; if (acc_16[4][4] !== 16'hFFFC) begin failures++; $display("FAIL arith_wrap44 act=%h exp fffc", acc_16[4][4]); end
`endif
        ack();
        checks++; if (acc_16 !== '0 || aval_16 !== 1'b0) begin failures++; $display("FAIL arith_clear aval=%b", aval_16); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stride = 3'd1; tile_valid = 1'b0; acc_ready = 1'b0;
        fill(16'd0);
        test_reset();
        test_basic();
        test_stride2();
        test_drop();
        test_backpressure();
        test_control();
        test_arith();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
